// File: rtl/vme_sysctl_pkg.sv
// Shared constants and helpers for the VME slot-1 system controller.
// All backplane signals are active-low; ASSERTED/NEGATED name the two levels.
package vme_sysctl_pkg;

  localparam int DEF_BUS_TIMEOUT   = 256;
  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int DEF_TIMER_WIDTH   = 9;

  // One-hot arbiter states
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_GRANT = 3'b010;
  localparam logic [2:0] ST_BUSY  = 3'b100;

  localparam logic [1:0] LVL0 = 2'd0;
  localparam logic [1:0] LVL1 = 2'd1;
  localparam logic [1:0] LVL2 = 2'd2;
  localparam logic [1:0] LVL3 = 2'd3;

  localparam logic ASSERTED = 1'b0;
  localparam logic NEGATED  = 1'b1;

  function automatic logic [1:0] fixed_winner(input logic [3:0] req_n);
    logic [1:0] win;
    if (req_n[3] == ASSERTED) begin
      win = LVL3;
    end else if (req_n[2] == ASSERTED) begin
      win = LVL2;
    end else if (req_n[1] == ASSERTED) begin
      win = LVL1;
    end else begin
      win = LVL0;
    end
    return win;
  endfunction

  // Search downward from one level below the last grant, wrapping 0 -> 3
  function automatic logic [1:0] rr_winner(input logic [3:0] req_n, input logic [1:0] last);
    logic [1:0] win;
    logic [1:0] lvl;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      lvl = last - 2'(i);
      if (!found && req_n[lvl] == ASSERTED) begin
        win   = lvl;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] above_mask(input logic [1:0] lvl);
    return 4'(4'b1110 << lvl);
  endfunction

endpackage

// File: rtl/vme_system_controller_if.sv
// Backplane-side signal bundle of the system controller.
// master = the controller, slave = the backplane/bench side.
interface vme_system_controller_if;
  logic [3:0] vme_br;
  logic       vme_bbsy;
  logic       vme_as;
  logic [1:0] vme_ds;
  logic       vme_dtack;
  logic       vme_berr_in;
  logic [3:0] vme_bg_out;
  logic       vme_bclr;
  logic       vme_berr_out;
  logic [1:0] bus_owner;
  logic       bus_busy;

  modport master (
    input  vme_br, vme_bbsy, vme_as, vme_ds, vme_dtack, vme_berr_in,
    output vme_bg_out, vme_bclr, vme_berr_out, bus_owner, bus_busy
  );

  modport slave (
    output vme_br, vme_bbsy, vme_as, vme_ds, vme_dtack, vme_berr_in,
    input  vme_bg_out, vme_bclr, vme_berr_out, bus_owner, bus_busy
  );
endinterface

// File: rtl/vme_bus_timer.sv
// Data-transfer bus timer: drives BERR when a DS cycle gets no DTACK/BERR
// within BUS_TIMEOUT clocks of the synchronised strobes.
module vme_bus_timer
  import vme_sysctl_pkg::*;
#(
  parameter int BUS_TIMEOUT = DEF_BUS_TIMEOUT,
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sysctl_enable,
  input  logic       vme_as,
  input  logic [1:0] vme_ds,
  input  logic       vme_dtack,
  input  logic       vme_berr_in,
  output logic       vme_berr_out
);

  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(BUS_TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] FIRE_AT     = TIMER_WIDTH'(BUS_TIMEOUT - 1);

  logic [4:0]             meta_r;
  logic [4:0]             sync_r;
  logic [TIMER_WIDTH-1:0] cnt_r;
  logic                   stopped_r;
  logic                   berr_r;
  logic                   as_s;
  logic [1:0]             ds_s;
  logic                   armed_s;
  logic                   ack_s;

  // Two-flop synchroniser for {BERR_in, DTACK, DS1, DS0, AS}
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_r <= 5'h1F;
      sync_r <= 5'h1F;
    end else begin
      meta_r <= {vme_berr_in, vme_dtack, vme_ds, vme_as};
      sync_r <= meta_r;
    end
  end

  assign as_s    = sync_r[0];
  assign ds_s    = sync_r[2:1];
  assign armed_s = (as_s == ASSERTED) && (ds_s != 2'b11);
  assign ack_s   = (sync_r[3] == ASSERTED) || (sync_r[4] == ASSERTED);

  // Timeout counter; a slave response freezes it until both DS release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r     <= '0;
      stopped_r <= 1'b0;
      berr_r    <= NEGATED;
    end else if (!sysctl_enable || ds_s == 2'b11) begin
      cnt_r     <= '0;
      stopped_r <= 1'b0;
      berr_r    <= NEGATED;
    end else if (armed_s && !stopped_r) begin
      if (ack_s) begin
        stopped_r <= 1'b1;
      end else if (cnt_r == FIRE_AT) begin
        cnt_r  <= TIMEOUT_VAL;
        berr_r <= ASSERTED;
      end else if (cnt_r != TIMEOUT_VAL) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign vme_berr_out = berr_r;

endmodule

// File: rtl/vme_system_controller.sv
// VME slot-1 system controller: 4-level bus arbiter plus data-transfer bus timer.
// Build option VME_ARB_ROUND_ROBIN_EN selects round-robin arbitration (BCLR unused).
module vme_system_controller
  import vme_sysctl_pkg::*;
#(
  parameter int BUS_TIMEOUT   = DEF_BUS_TIMEOUT,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int TIMER_WIDTH   = DEF_TIMER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sysctl_enable,
  vme_system_controller_if.master  bus
);

  localparam logic [TIMER_WIDTH-1:0] GRANT_LAST = TIMER_WIDTH'(GRANT_TIMEOUT - 1);

  logic [3:0]             br_meta_r;
  logic [3:0]             br_sync_r;
  logic                   bbsy_meta_r;
  logic                   bbsy_sync_r;
  logic [2:0]             state_r;
  logic [2:0]             state_nxt_s;
  logic [1:0]             owner_r;
  logic [1:0]             owner_nxt_s;
  logic [1:0]             winner_s;
  logic [TIMER_WIDTH-1:0] grant_cnt_r;
  logic [TIMER_WIDTH-1:0] grant_cnt_nxt_s;
  logic [3:0]             bg_r;
  logic [3:0]             bg_nxt_s;
  logic                   busy_r;

  // Two-flop synchronisers for the arbitration inputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      br_meta_r   <= 4'hF;
      br_sync_r   <= 4'hF;
      bbsy_meta_r <= NEGATED;
      bbsy_sync_r <= NEGATED;
    end else begin
      br_meta_r   <= bus.vme_br;
      br_sync_r   <= br_meta_r;
      bbsy_meta_r <= bus.vme_bbsy;
      bbsy_sync_r <= bbsy_meta_r;
    end
  end

`ifdef VME_ARB_ROUND_ROBIN_EN
  assign winner_s     = rr_winner(br_sync_r, owner_r);
  assign bus.vme_bclr = NEGATED;
`else
  logic higher_req_s;
  assign winner_s     = fixed_winner(br_sync_r);
  assign higher_req_s = |(~br_sync_r & above_mask(owner_r));
  // Decoded from registered state so it follows BUSY exit on the same edge
  assign bus.vme_bclr = (state_r == ST_BUSY && higher_req_s) ? ASSERTED : NEGATED;
`endif

  // Arbiter next-state and grant-counter logic
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    grant_cnt_nxt_s = grant_cnt_r;
    case (state_r)
      ST_IDLE: begin
        grant_cnt_nxt_s = '0;
        if (bbsy_sync_r == NEGATED && br_sync_r != 4'hF) begin
          state_nxt_s = ST_GRANT;
          owner_nxt_s = winner_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bbsy_sync_r == ASSERTED) begin
          state_nxt_s     = ST_BUSY;
          grant_cnt_nxt_s = '0;
        end else if (grant_cnt_r == GRANT_LAST) begin
          grant_cnt_nxt_s = '0;
          if (br_sync_r[owner_r] == NEGATED) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_GRANT;
          end
        end else begin
          grant_cnt_nxt_s = grant_cnt_r + 1'b1;
        end
      end
      ST_BUSY: begin
        if (bbsy_sync_r == NEGATED) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        owner_nxt_s     = LVL0;
        grant_cnt_nxt_s = '0;
      end
    endcase
  end

  // Grant head for the next state so BG is low on the entry edge
  always_comb begin
    bg_nxt_s = 4'hF;
    if (state_nxt_s == ST_GRANT) begin
      bg_nxt_s[owner_nxt_s] = ASSERTED;
    end else begin
      bg_nxt_s = 4'hF;
    end
  end

  // Arbiter state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= LVL0;
      grant_cnt_r <= '0;
      bg_r        <= 4'hF;
      busy_r      <= 1'b0;
    end else if (!sysctl_enable) begin
      state_r     <= ST_IDLE;
      owner_r     <= LVL0;
      grant_cnt_r <= '0;
      bg_r        <= 4'hF;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      grant_cnt_r <= grant_cnt_nxt_s;
      bg_r        <= bg_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.vme_bg_out = bg_r;
  assign bus.bus_owner  = owner_r;
  assign bus.bus_busy   = busy_r;

  vme_bus_timer #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_bus_timer (
    .clock         (clock),
    .reset         (reset),
    .sysctl_enable (sysctl_enable),
    .vme_as        (bus.vme_as),
    .vme_ds        (bus.vme_ds),
    .vme_dtack     (bus.vme_dtack),
    .vme_berr_in   (bus.vme_berr_in),
    .vme_berr_out  (bus.vme_berr_out)
  );

endmodule

// File: tb/tb_vme_system_controller.sv
// Directed bench for vme_system_controller (default fixed-priority build).
module tb_vme_system_controller;

  logic clock;
  logic reset;
  logic sysctl_enable;
  int   checks;
  int   errors;

  vme_system_controller_if bus_if ();

  vme_system_controller dut (
    .clock         (clock),
    .reset         (reset),
    .sysctl_enable (sysctl_enable),
    .bus           (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] br;
    logic [1:0] exp_owner;
    logic [3:0] exp_bg;
  } arb_vec_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic claim_and_release();
    bus_if.vme_bbsy = 1'b0;
    bus_if.vme_br   = 4'hF;
    tick(3);
    bus_if.vme_bbsy = 1'b1;
    tick(3);
  endtask

  arb_vec_t vecs [8];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{br: 4'b1110, exp_owner: 2'd0, exp_bg: 4'b1110};
    vecs[1] = '{br: 4'b1101, exp_owner: 2'd1, exp_bg: 4'b1101};
    vecs[2] = '{br: 4'b1011, exp_owner: 2'd2, exp_bg: 4'b1011};
    vecs[3] = '{br: 4'b0111, exp_owner: 2'd3, exp_bg: 4'b0111};
    vecs[4] = '{br: 4'b0000, exp_owner: 2'd3, exp_bg: 4'b0111};
    vecs[5] = '{br: 4'b1100, exp_owner: 2'd1, exp_bg: 4'b1101};
    vecs[6] = '{br: 4'b1010, exp_owner: 2'd2, exp_bg: 4'b1011};
    vecs[7] = '{br: 4'b1001, exp_owner: 2'd2, exp_bg: 4'b1011};

    reset              = 1'b0;
    sysctl_enable      = 1'b1;
    bus_if.vme_br      = 4'hF;
    bus_if.vme_bbsy    = 1'b1;
    bus_if.vme_as      = 1'b1;
    bus_if.vme_ds      = 2'b11;
    bus_if.vme_dtack   = 1'b1;
    bus_if.vme_berr_in = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);

    check("rst_bg",    32'(bus_if.vme_bg_out),   32'hF);
    check("rst_bclr",  32'(bus_if.vme_bclr),     32'h1);
    check("rst_berr",  32'(bus_if.vme_berr_out), 32'h1);
    check("rst_owner", 32'(bus_if.bus_owner),    32'h0);
    check("rst_busy",  32'(bus_if.bus_busy),     32'h0);
    tick(2);

    // Table: request pattern -> winner, then claim and release
    for (int i = 0; i < 8; i++) begin
      bus_if.vme_br = vecs[i].br;
      tick(3);
      check("vec_owner", 32'(bus_if.bus_owner),  32'(vecs[i].exp_owner));
      check("vec_bg",    32'(bus_if.vme_bg_out), 32'(vecs[i].exp_bg));
      check("vec_busy",  32'(bus_if.bus_busy),   32'h1);
      bus_if.vme_bbsy = 1'b0;
      bus_if.vme_br   = 4'hF;
      tick(3);
      check("vec_busy_bg", 32'(bus_if.vme_bg_out), 32'hF);
      bus_if.vme_bbsy = 1'b1;
      tick(3);
      check("vec_idle", 32'(bus_if.bus_busy), 32'h0);
    end

    // Priority: levels 3 and 0 together, then level 0 after release
    bus_if.vme_br = 4'b0110;
    tick(3);
    check("prio_owner", 32'(bus_if.bus_owner),  32'h3);
    check("prio_bg",    32'(bus_if.vme_bg_out), 32'h7);
    bus_if.vme_bbsy = 1'b0;
    bus_if.vme_br   = 4'b1110;
    tick(3);
    check("prio_busy_bg", 32'(bus_if.vme_bg_out), 32'hF);
    check("prio_bclr",    32'(bus_if.vme_bclr),   32'h1);
    bus_if.vme_bbsy = 1'b1;
    tick(4);
    check("prio_next_owner", 32'(bus_if.bus_owner),  32'h0);
    check("prio_next_bg",    32'(bus_if.vme_bg_out), 32'hE);
    claim_and_release();

    // BCLR: level 1 busy, level 2 requests
    bus_if.vme_br = 4'b1101;
    tick(3);
    check("bclr_owner", 32'(bus_if.bus_owner), 32'h1);
    bus_if.vme_bbsy = 1'b0;
    tick(3);
    bus_if.vme_br = 4'b1001;
    tick(1);
    check("bclr_early", 32'(bus_if.vme_bclr), 32'h1);
    tick(1);
    check("bclr_low", 32'(bus_if.vme_bclr), 32'h0);
    bus_if.vme_bbsy = 1'b1;
    bus_if.vme_br   = 4'b1011;
    tick(2);
    check("bclr_hold", 32'(bus_if.vme_bclr), 32'h0);
    tick(1);
    check("bclr_rel",    32'(bus_if.vme_bclr),   32'h1);
    check("bclr_rel_bg", 32'(bus_if.vme_bg_out), 32'hF);
    tick(1);
    check("bclr_bg2",   32'(bus_if.vme_bg_out), 32'hB);
    check("bclr_owner2", 32'(bus_if.bus_owner), 32'h2);
    claim_and_release();

    // Unclaimed grant withdrawn after 16 clocks
    bus_if.vme_br = 4'b1110;
    tick(3);
    check("ung_bg", 32'(bus_if.vme_bg_out), 32'hE);
    bus_if.vme_br = 4'hF;
    tick(15);
    check("ung_bg_15", 32'(bus_if.vme_bg_out), 32'hE);
    tick(1);
    check("ung_bg_16", 32'(bus_if.vme_bg_out), 32'hF);
    check("ung_idle",  32'(bus_if.bus_busy),   32'h0);
    tick(3);

    // Unclaimed grant with request still held: grant kept
    bus_if.vme_br = 4'b1110;
    tick(3);
    tick(16);
    check("hold_bg",   32'(bus_if.vme_bg_out), 32'hE);
    check("hold_busy", 32'(bus_if.bus_busy),   32'h1);
    bus_if.vme_br = 4'hF;
    tick(16);
    check("hold_rel_bg", 32'(bus_if.vme_bg_out), 32'hF);
    tick(3);

    // sysctl_enable low releases everything on the next clock
    bus_if.vme_br = 4'b1101;
    tick(3);
    check("en_bg", 32'(bus_if.vme_bg_out), 32'hD);
    sysctl_enable = 1'b0;
    bus_if.vme_br = 4'hF;
    tick(1);
    check("dis_bg",    32'(bus_if.vme_bg_out), 32'hF);
    check("dis_busy",  32'(bus_if.bus_busy),   32'h0);
    check("dis_owner", 32'(bus_if.bus_owner),  32'h0);
    tick(3);
    sysctl_enable = 1'b1;
    tick(2);
    check("reen_bg", 32'(bus_if.vme_bg_out), 32'hF);

    // Bus timeout: AS + DS0, no response
    bus_if.vme_as = 1'b0;
    bus_if.vme_ds = 2'b10;
    tick(257);
    check("to_before", 32'(bus_if.vme_berr_out), 32'h1);
    tick(1);
    check("to_fire", 32'(bus_if.vme_berr_out), 32'h0);
    tick(5);
    check("to_sat", 32'(bus_if.vme_berr_out), 32'h0);
    bus_if.vme_ds = 2'b11;
    tick(2);
    check("to_ds_hold", 32'(bus_if.vme_berr_out), 32'h0);
    tick(1);
    check("to_ds_rel", 32'(bus_if.vme_berr_out), 32'h1);
    bus_if.vme_as = 1'b1;
    tick(3);

    // DTACK at clock 100 stops the timer for this cycle
    bus_if.vme_as = 1'b0;
    bus_if.vme_ds = 2'b10;
    tick(98);
    bus_if.vme_dtack = 1'b0;
    tick(162);
    check("dtack_260", 32'(bus_if.vme_berr_out), 32'h1);
    tick(40);
    check("dtack_300", 32'(bus_if.vme_berr_out), 32'h1);
    bus_if.vme_ds    = 2'b11;
    bus_if.vme_as    = 1'b1;
    bus_if.vme_dtack = 1'b1;
    tick(4);

    // Asynchronous reset in the middle of a grant
    bus_if.vme_br = 4'b1011;
    tick(3);
    check("mid_bg", 32'(bus_if.vme_bg_out), 32'hB);
    #2;
    reset = 1'b0;
    #1;
    check("arst_bg",   32'(bus_if.vme_bg_out), 32'hF);
    check("arst_busy", 32'(bus_if.bus_busy),   32'h0);
    bus_if.vme_br = 4'hF;
    tick(2);
    reset = 1'b1;
    tick(3);
    check("post_rst_bg", 32'(bus_if.vme_bg_out), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
